// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data.
// Depth is 2**ADDR_WIDTH words of BUS_WIDTH bits. The read and write pointers
// carry one extra MSB so that a full FIFO and an empty one can be told apart.
// Optional feature: define FIFO_LEVEL_EN to add a 'level' output that reports
// the current occupancy (0..DEPTH).
module fifo #(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] wr_data,
    input  logic                 wr,
    input  logic                 rd,
    output logic [BUS_WIDTH-1:0] rd_data,
    output logic                 full,
    output logic                 empty_n
`ifdef FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]  level
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [BUS_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]  wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH:0]  rdPtr_q, rdPtr_d;
    logic [BUS_WIDTH-1:0] rdData_q, rdData_d;

    logic wrAccept;
    logic rdAccept;

    // Status flags come straight from the registered pointers, so they
    // change in the cycle after the edge that moved a pointer.
    always_comb begin
        full    = (wrPtr_q[ADDR_WIDTH] != rdPtr_q[ADDR_WIDTH]) &&
                  (wrPtr_q[ADDR_WIDTH-1:0] == rdPtr_q[ADDR_WIDTH-1:0]);
        empty_n = (wrPtr_q != rdPtr_q);
    end

    // A read is taken whenever data is present. A write is taken when there
    // is room, or when the FIFO is full but a read frees a slot this edge.
    always_comb begin
        rdAccept = rd && empty_n;
        wrAccept = wr && (!full || rdAccept);
    end

    // Next-state for pointers and the read data register; unaccepted
    // requests leave everything (including rd_data) untouched.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        rdData_d = rdData_q;
        if (wrAccept) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (rdAccept) begin
            rdPtr_d  = rdPtr_q + 1'b1;
            rdData_d = mem[rdPtr_q[ADDR_WIDTH-1:0]];
        end
    end

    // Pointer and read-data registers; reset clears them without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            rdData_q <= '0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            rdData_q <= rdData_d;
        end
    end

    // Storage array is deliberately not reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem[wrPtr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    assign rd_data = rdData_q;

`ifdef FIFO_LEVEL_EN
    assign level = wrPtr_q - rdPtr_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo (BUS_WIDTH=4, default depth of 4).
// A queue models the FIFO contents: words are pushed when the bench drives an
// accepted write and popped when it drives an accepted read; the popped word
// is compared with rd_data right after the edge.
module tb_fifo;

    localparam int BW    = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic [BW-1:0] wr_data;
    logic          wr;
    logic          rd;
    logic [BW-1:0] rd_data;
    logic          full;
    logic          empty_n;
`ifdef FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] sb[$];
    logic [BW-1:0] lastRd;

    fifo #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (wr_data),
        .wr      (wr),
        .rd      (rd),
        .rd_data (rd_data),
        .full    (full),
        .empty_n (empty_n)
`ifdef FIFO_LEVEL_EN
        ,
        .level   (level)
`endif
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the status flags against the model occupancy.
    task automatic checkFlags(input string tag);
        checkOutput({tag, "_full"}, 32'(full), 32'(sb.size() == DEPTH));
        checkOutput({tag, "_empty_n"}, 32'(empty_n), 32'(sb.size() != 0));
`ifdef FIFO_LEVEL_EN
        checkOutput({tag, "_level"}, 32'(level), 32'(sb.size()));
`endif
    endtask

    // Drive one cycle of wr/rd, update the model, then check after the edge.
    task automatic applyStimulus(input string tag, input logic w, input logic r, input logic [BW-1:0] d);
        bit            wrOk;
        bit            rdOk;
        logic [BW-1:0] expRd;
        wr      = w;
        rd      = r;
        wr_data = d;
        rdOk  = r && (sb.size() > 0);
        wrOk  = w && ((sb.size() < DEPTH) || rdOk);
        expRd = lastRd;
        if (rdOk) begin
            expRd = sb.pop_front();
        end
        if (wrOk) begin
            sb.push_back(d);
        end
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        lastRd = expRd;
        checkOutput({tag, "_rd_data"}, 32'(rd_data), 32'(expRd));
        checkFlags(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        wr_data = '0;
        lastRd  = '0;
        #12;
        checkOutput("reset_rd_data", 32'(rd_data), 32'(0));
        checkFlags("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word round trip.
        applyStimulus("single_wr", 1'b1, 1'b0, 4'b0110);
        applyStimulus("single_idle", 1'b0, 1'b0, 4'h0);
        applyStimulus("single_rd", 1'b0, 1'b1, 4'h0);
        applyStimulus("single_after", 1'b0, 1'b0, 4'h0);

        // Fill to full, overflow attempt, drain, extra read on empty.
        for (int i = 1; i <= 4; i++) applyStimulus("fill", 1'b1, 1'b0, 4'(i));
        applyStimulus("overflow", 1'b1, 1'b0, 4'd5);
        for (int i = 0; i < 4; i++) applyStimulus("drain", 1'b0, 1'b1, 4'h0);
        applyStimulus("underflow", 1'b0, 1'b1, 4'h0);

        // Alternate fill/drain three times so the pointers wrap.
        for (int blk = 0; blk < 3; blk++) begin
            for (int i = 0; i < 4; i++) applyStimulus("wrap_wr", 1'b1, 1'b0, 4'(blk * 4 + i));
            for (int i = 0; i < 4; i++) applyStimulus("wrap_rd", 1'b0, 1'b1, 4'h0);
        end

        // Reads on empty, then simultaneous read/write on empty.
        for (int i = 0; i < 3; i++) applyStimulus("empty_rd", 1'b0, 1'b1, 4'h0);
        applyStimulus("empty_wrrd", 1'b1, 1'b1, 4'd9);
        applyStimulus("mid_wrrd", 1'b1, 1'b1, 4'd3);
        applyStimulus("empty_out", 1'b0, 1'b1, 4'h0);

        // Simultaneous read/write while full.
        for (int i = 0; i < 4; i++) applyStimulus("full_fill", 1'b1, 1'b0, 4'(10 + i));
        applyStimulus("full_wrrd", 1'b1, 1'b1, 4'd14);
        for (int i = 0; i < 4; i++) applyStimulus("full_drain", 1'b0, 1'b1, 4'h0);

        // Asynchronous reset between edges with two words stored.
        applyStimulus("pre_rst_wr", 1'b1, 1'b0, 4'd5);
        applyStimulus("pre_rst_wr", 1'b1, 1'b0, 4'd6);
        applyStimulus("pre_rst_wr", 1'b1, 1'b0, 4'd7);
        applyStimulus("pre_rst_rd", 1'b0, 1'b1, 4'h0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        lastRd = '0;
        #1;
        checkOutput("async_rst_rd_data", 32'(rd_data), 32'(0));
        checkFlags("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkFlags("post_rst");

        // Fresh behaviour after reset.
        applyStimulus("post_wr", 1'b1, 1'b0, 4'd8);
        applyStimulus("post_rd", 1'b0, 1'b1, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
